// File: rtl/demux_stream_router_1x4.sv
// demux_stream_router_1x4: registered 1-to-4 valid/ready stream router.
// Define ROUTER_BEAT_COUNT_EN to add the beat_count output.
module demux_stream_router_1x4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               rr_mode,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
`ifdef ROUTER_BEAT_COUNT_EN
  output logic [15:0]        beat_count,
`endif
  output logic [1:0]         rr_ptr
);

  logic [1:0] tgt;
  logic       accept;
  logic [3:0] load;

  assign tgt      = rr_mode ? rr_ptr : in_sel;
  assign in_ready = !out_valid[tgt] || out_ready[tgt];
  assign accept   = in_valid && in_ready;

  always_comb begin
    load = '0;
    unique case (tgt)
      2'd0: load[0] = accept;
      2'd1: load[1] = accept;
      2'd2: load[2] = accept;
      2'd3: load[3] = accept;
      default: load = '0;
    endcase
  end

  // A load on the same edge as a drain keeps the lane valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) begin
          out_data[i*WIDTH +: WIDTH] <= in_data;
          out_valid[i]               <= 1'b1;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 2'd0;
    end else if (accept && rr_mode) begin
      rr_ptr <= rr_ptr + 2'd1;
    end
  end

`ifdef ROUTER_BEAT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count <= 16'd0;
    end else if (accept) begin
      beat_count <= beat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_stream_router_1x4.sv
// Directed self-checking bench for demux_stream_router_1x4.
// Builds with or without ROUTER_BEAT_COUNT_EN.
module tb_demux_stream_router_1x4;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [W-1:0]   in_data = '0;
  logic [1:0]     in_sel = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           rr_mode = 1'b0;
  logic [4*W-1:0] out_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready = '0;
  logic [1:0]     rr_ptr;
`ifdef ROUTER_BEAT_COUNT_EN
  logic [15:0]    beat_count;
`endif

  int checks = 0;
  int errors = 0;

  demux_stream_router_1x4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rr_mode   (rr_mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef ROUTER_BEAT_COUNT_EN
    .beat_count(beat_count),
`endif
    .rr_ptr    (rr_ptr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL reset_valid: got %b exp 0000", out_valid);
    end
    checks++;
    if (rr_ptr !== 2'd0) begin
      errors++;
      $display("FAIL reset_ptr: got %0d exp 0", rr_ptr);
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h exp 0", out_data);
    end
`ifdef ROUTER_BEAT_COUNT_EN
    checks++;
    if (beat_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d exp 0", beat_count);
    end
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sel();
    logic [W-1:0] exp_d;
    rr_mode   = 1'b0;
    out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      exp_d    = 8'hA0 + W'(k);
      in_sel   = 2'(k);
      in_data  = exp_d;
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL sel_ready[%0d]: got %b exp 1", k, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== (4'b0001 << k)) begin
        errors++;
        $display("FAIL sel_valid[%0d]: got %b exp %b", k, out_valid,
                 4'b0001 << k);
      end
      checks++;
      if (out_data[k*W +: W] !== exp_d) begin
        errors++;
        $display("FAIL sel_data[%0d]: got %h exp %h", k,
                 out_data[k*W +: W], exp_d);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL sel_drain: got %b exp 0000", out_valid);
    end
  endtask

  task automatic test_rr();
    logic [W-1:0] exp_d;
    int           lane;
    rr_mode   = 1'b1;
    out_ready = 4'b1111;
    in_sel    = 2'd3;
    for (int k = 0; k < 6; k++) begin
      lane     = k % 4;
      exp_d    = 8'h10 + W'(k);
      in_data  = exp_d;
      in_valid = 1'b1;
      #1;
      checks++;
      if (rr_ptr !== 2'(lane)) begin
        errors++;
        $display("FAIL rr_ptr[%0d]: got %0d exp %0d", k, rr_ptr, lane);
      end
      tick();
      checks++;
      if (out_valid !== (4'b0001 << lane)) begin
        errors++;
        $display("FAIL rr_valid[%0d]: got %b exp %b", k, out_valid,
                 4'b0001 << lane);
      end
      checks++;
      if (out_data[lane*W +: W] !== exp_d) begin
        errors++;
        $display("FAIL rr_data[%0d]: got %h exp %h", k,
                 out_data[lane*W +: W], exp_d);
      end
    end
    in_valid = 1'b0;
    rr_mode  = 1'b0;
    checks++;
    if (rr_ptr !== 2'd2) begin
      errors++;
      $display("FAIL rr_wrap: got %0d exp 2", rr_ptr);
    end
    in_sel   = 2'd1;
    in_data  = 8'hEE;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (rr_ptr !== 2'd2) begin
      errors++;
      $display("FAIL rr_hold: got %0d exp 2", rr_ptr);
    end
    tick();
  endtask

  task automatic test_stall();
    rr_mode   = 1'b0;
    out_ready = 4'b1011;
    in_sel    = 2'd2;
    in_data   = 8'h55;
    in_valid  = 1'b1;
    tick();
    checks++;
    if (out_valid[2] !== 1'b1 || out_data[2*W +: W] !== 8'h55) begin
      errors++;
      $display("FAIL stall_cap: got v=%b d=%h exp v=1 d=55",
               out_valid[2], out_data[2*W +: W]);
    end
    in_data = 8'h66;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_ready: got %b exp 0", in_ready);
    end
    tick();
    checks++;
    if (out_valid[2] !== 1'b1 || out_data[2*W +: W] !== 8'h55) begin
      errors++;
      $display("FAIL stall_hold: got v=%b d=%h exp v=1 d=55",
               out_valid[2], out_data[2*W +: W]);
    end
    in_valid = 1'b0;
    tick();
    in_sel   = 2'd1;
    in_data  = 8'h77;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bypass_ready: got %b exp 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0110) begin
      errors++;
      $display("FAIL bypass_valid: got %b exp 0110", out_valid);
    end
    checks++;
    if (out_data[1*W +: W] !== 8'h77 || out_data[2*W +: W] !== 8'h55) begin
      errors++;
      $display("FAIL bypass_data: got l1=%h l2=%h exp 77 55",
               out_data[1*W +: W], out_data[2*W +: W]);
    end
    tick();
    in_sel    = 2'd2;
    in_data   = 8'h66;
    in_valid  = 1'b1;
    out_ready = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: got %b exp 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0100 || out_data[2*W +: W] !== 8'h66) begin
      errors++;
      $display("FAIL release_data: got v=%b d=%h exp v=0100 d=66",
               out_valid, out_data[2*W +: W]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_d;
    rr_mode   = 1'b0;
    out_ready = 4'b1111;
    in_sel    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      exp_d    = 8'h99 + W'(k);
      in_data  = exp_d;
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b exp 1", k, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 4'b0001 || out_data[0 +: W] !== exp_d) begin
        errors++;
        $display("FAIL b2b_data[%0d]: got v=%b d=%h exp v=0001 d=%h",
                 k, out_valid, out_data[0 +: W], exp_d);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_drain: got %b exp 0000", out_valid);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 4'b0000;
    rr_mode   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data  = 8'hC0 + W'(k);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b1101 || rr_ptr !== 2'd1) begin
      errors++;
      $display("FAIL pre_rst: got v=%b p=%0d exp v=1101 p=1",
               out_valid, rr_ptr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0000 || rr_ptr !== 2'd0) begin
      errors++;
      $display("FAIL async_rst: got v=%b p=%0d exp v=0000 p=0",
               out_valid, rr_ptr);
    end
`ifdef ROUTER_BEAT_COUNT_EN
    checks++;
    if (beat_count !== 16'd0) begin
      errors++;
      $display("FAIL async_cnt: got %0d exp 0", beat_count);
    end
`endif
    #1 rst_n = 1'b1;
    tick();
    out_ready = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      in_data  = 8'hD0 + W'(k);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (rr_ptr !== 2'd1) begin
      errors++;
      $display("FAIL post_rst_ptr: got %0d exp 1", rr_ptr);
    end
`ifdef ROUTER_BEAT_COUNT_EN
    checks++;
    if (beat_count !== 16'd5) begin
      errors++;
      $display("FAIL post_rst_cnt: got %0d exp 5", beat_count);
    end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_sel();
    test_rr();
    test_stall();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
